// File: rtl/serial_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_cell_sequencer
// Brief    : Bit-serial controller that drives two WIDTH-bit operands through
//            a single combinational 1-bit cell, LSB first. Each cycle's K_out
//            becomes the next cycle's K_in, and the U bits are collected into
//            a WIDTH-bit result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_cell_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             k0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             k_final,
    output logic             cell_en,
    output logic             cell_x,
    output logic             cell_y,
    output logic             cell_kin,
    input  logic             cell_u,
    input  logic             cell_kout
);

    // Counter just wide enough to reach WIDTH-1.
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_a_sr;
    logic [WIDTH-1:0]     r_b_sr;
    logic [WIDTH-1:0]     r_res_sr;
    logic                 r_carry;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_k_final;

    logic                 w_last;
    logic [WIDTH-1:0]     w_res_next;

    // Final-bit detect and the result shift register including this cycle's U.
    assign w_last     = (r_cnt == c_LAST);
    assign w_res_next = {cell_u, r_res_sr[WIDTH-1:1]};

    assign result  = r_result;
    assign k_final = r_k_final;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and cell/handshake outputs; cell drive comes only from registers.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        cell_en  = 1'b0;
        cell_x   = 1'b0;
        cell_y   = 1'b0;
        cell_kin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                cell_en  = 1'b1;
                cell_x   = r_a_sr[0];
                cell_y   = r_b_sr[0];
                cell_kin = r_carry;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand shifting, carry feedback, bit counting and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_res_sr  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_k_final <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_res_sr <= '0;
                        r_carry  <= k0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Cancelled: previous result and k_final stay visible.
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                        r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                        r_res_sr <= w_res_next;
                        r_carry  <= cell_kout;
                        r_cnt    <= r_cnt + c_CNT_W'(1);
                        if (w_last) begin
                            r_result  <= w_res_next;
                            r_k_final <= cell_kout;
                            r_cnt     <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cell_sequencer
// Brief    : Self-checking bench: behavioural full-adder cell model around an
//            8-bit and a 4-bit sequencer, scoreboard of expected sums.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_cell_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 8-bit instance signals
    logic       start = 1'b0, abort = 1'b0, k0 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, k_final, cell_en, cell_x, cell_y, cell_kin;
    logic [7:0] result;
    logic       cell_u, cell_kout;

    // 4-bit instance signals
    logic       start4 = 1'b0, abort4 = 1'b0, k04 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, k_final4, cell_en4, cell_x4, cell_y4, cell_kin4;
    logic [3:0] result4;
    logic       cell_u4, cell_kout4;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt8 = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    // Cell models: gated full adder.
    assign cell_u     = cell_en & (cell_x ^ cell_y ^ cell_kin);
    assign cell_kout  = cell_en & ((cell_x & cell_y) | (cell_x & cell_kin) | (cell_y & cell_kin));
    assign cell_u4    = cell_en4 & (cell_x4 ^ cell_y4 ^ cell_kin4);
    assign cell_kout4 = cell_en4 & ((cell_x4 & cell_y4) | (cell_x4 & cell_kin4) | (cell_y4 & cell_kin4));

    serial_cell_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b), .k0(k0),
        .busy(busy), .done(done), .result(result), .k_final(k_final),
        .cell_en(cell_en), .cell_x(cell_x), .cell_y(cell_y), .cell_kin(cell_kin),
        .cell_u(cell_u), .cell_kout(cell_kout)
    );

    serial_cell_sequencer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .a(a4), .b(b4), .k0(k04),
        .busy(busy4), .done(done4), .result(result4), .k_final(k_final4),
        .cell_en(cell_en4), .cell_x(cell_x4), .cell_y(cell_y4), .cell_kin(cell_kin4),
        .cell_u(cell_u4), .cell_kout(cell_kout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 8-bit instance: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 16'd1, 16'd0);
            end else begin
                check("result8", {7'd0, k_final, result}, {7'd0, q8.pop_front()});
            end
        end
    end

    // Scoreboard for the 4-bit instance.
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                check("done4_unexpected", 16'd1, 16'd0);
            end else begin
                check("result4", {11'd0, k_final4, result4}, {11'd0, q4.pop_front()});
            end
        end
    end

    // Full operation on the 8-bit instance with latency and handshake checks.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ik);
        a = ia; b = ib; k0 = ik; start = 1'b1;
        q8.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ik});
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; k0 = ~ik;   // must not disturb the running operation
        for (int i = 0; i < 8; i++) begin
            check("busy_run", {15'd0, busy}, 16'd1);
            check("en_run", {15'd0, cell_en}, 16'd1);
            tick();
        end
        check("done_pulse", {15'd0, done}, 16'd1);
        check("busy_done", {15'd0, busy}, 16'd0);
        check("en_done", {15'd0, cell_en}, 16'd0);
        tick();
        check("done_clear", {15'd0, done}, 16'd0);
        check("en_idle", {15'd0, cell_en}, 16'd0);
    endtask

    initial begin
        int dc;
        repeat (2) tick();
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_result", {8'd0, result}, 16'd0);
        check("rst_kfinal", {15'd0, k_final}, 16'd0);
        check("rst_cell", {12'd0, cell_en, cell_x, cell_y, cell_kin}, 16'd0);
        rst = 1'b0;
        tick();

        // Basic additions
        run_op(8'h35, 8'h4A, 1'b0);
        check("res_35_4a", {7'd0, k_final, result}, 16'h07F);
        run_op(8'hFF, 8'h01, 1'b0);
        check("res_ff_01", {7'd0, k_final, result}, 16'h100);
        run_op(8'h00, 8'h00, 1'b1);
        check("res_00_00_k", {7'd0, k_final, result}, 16'h001);

        // start during RUN is ignored
        dc = done_cnt8;
        a = 8'h12; b = 8'h34; k0 = 1'b0; start = 1'b1;
        q8.push_back(9'h046);
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("ignore_start_res", {8'd0, result}, 16'h046);
        check("ignore_start_dones", 16'(done_cnt8 - dc), 16'd1);
        check("ignore_start_idle", {15'd0, busy}, 16'd0);

        // abort at RUN cycle 4 after a 0x7F result
        run_op(8'h35, 8'h4A, 1'b0);
        dc = done_cnt8;
        a = 8'hAA; b = 8'h55; k0 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_result", {7'd0, k_final, result}, 16'h07F);
        repeat (10) tick();
        check("abort_no_done", 16'(done_cnt8 - dc), 16'd0);
        run_op(8'hAA, 8'h55, 1'b0);
        check("after_abort_res", {7'd0, k_final, result}, 16'h0FF);

        // abort on the final-bit edge wins
        dc = done_cnt8;
        a = 8'hFF; b = 8'hFF; k0 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_busy", {15'd0, busy}, 16'd0);
        check("abort_last_done", {15'd0, done}, 16'd0);
        check("abort_last_res", {7'd0, k_final, result}, 16'h0FF);
        repeat (3) tick();
        check("abort_last_no_done", 16'(done_cnt8 - dc), 16'd0);

        // abort together with start in IDLE: start wins
        a = 8'h0F; b = 8'h01; k0 = 1'b0; start = 1'b1; abort = 1'b1;
        q8.push_back(9'h010);
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_start", {15'd0, busy}, 16'd1);
        repeat (9) tick();
        check("idle_abort_res", {7'd0, k_final, result}, 16'h010);

        // Reset in the middle of RUN
        a = 8'h77; b = 8'h11; k0 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_result", {7'd0, k_final, result}, 16'd0);
        check("midrst_cell", {12'd0, cell_en, cell_x, cell_y, cell_kin}, 16'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_nostart_busy", {15'd0, busy}, 16'd0);
            check("idle_nostart_en", {15'd0, cell_en}, 16'd0);
        end

        // Exhaustive 4-bit sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ik = 0; ik < 2; ik++) begin
                    a4 = 4'(ia); b4 = 4'(ib); k04 = 1'(ik); start4 = 1'b1;
                    q4.push_back(5'(ia + ib + ik));
                    tick();
                    start4 = 1'b0;
                    repeat (5) tick();
                end
            end
        end
        tick();

        check("q8_drained", 16'(q8.size()), 16'd0);
        check("q4_drained", 16'(q4.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_cell_sequencer.md
Name: serial_cell_sequencer

Overview:
- Bit-serial controller for the team's 1-bit cell (inputs En, X, Y, K_in; outputs U, K_out).
- Accepts two WIDTH-bit operands and an initial K, then drives them through the single cell LSB-first, one bit per clock.
- Feeds each cycle's K_out back as the next cycle's K_in, and assembles the U bits into a WIDTH-bit result.
- Sits between a requesting host (start/done handshake) and one combinational cell instance.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  cancels an operation in RUN.
- a  input  WIDTH  operand fed to cell X.
- b  input  WIDTH  operand fed to cell Y.
- k0  input  1  initial K_in for bit 0.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result/k_final become valid.
- result  output  WIDTH  collected U bits; bit i = U of step i.
- k_final  output  1  K_out of step WIDTH-1.
- cell_en  output  1  to cell En.
- cell_x  output  1  to cell X.
- cell_y  output  1  to cell Y.
- cell_kin  output  1  to cell K_in.
- cell_u  input  1  from cell U.
- cell_kout  input  1  from cell K_out.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, result, k_final, cell_en, cell_x, cell_y, cell_kin and internal shift, carry and count registers all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cell_en=0; cell_x, cell_y and cell_kin forced to 0.
  - When start=1: load a_sr<=a, b_sr<=b, carry<=k0, cnt<=0, and go to RUN.
  - result and k_final are held.
- RUN:
  - Outputs: busy=1; cell_en=1; cell_x=a_sr[0]; cell_y=b_sr[0]; cell_kin=carry. These are combinational from registers, so no glitch from host inputs.
  - Each edge: a_sr and b_sr shift right; U is captured into res_sr MSB with a right shift; carry<=cell_kout; cnt<=cnt+1.
  - cnt is $clog2(WIDTH) bits wide and compares against WIDTH-1.
  - On the edge where cnt==WIDTH-1: result<=final res_sr (including the current cell_u), k_final<=cell_kout, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, cell_en=0.
  - Unconditionally returns to IDLE.
  - start in DONE is ignored and must be re-asserted in IDLE.
- Latency: start sampled at edge E0 gives RUN for edges E1..EWIDTH and done high during the cycle after EWIDTH, i.e. WIDTH+1 cycles after start.
- start while RUN or DONE: ignored; operands are not reloaded.
- abort:
  - Honoured only in RUN. The next edge goes to IDLE, with no done pulse.
  - result and k_final keep their previous values; carry and cnt are cleared.
  - abort and the final-bit edge together: abort wins.
  - abort in IDLE together with start: start wins; abort has no effect outside RUN.
- Reset mid-RUN: immediate return to IDLE with all outputs 0, including result.
- a, b and k0 may change after the start edge without effect.
- result and k_final are stable from the done cycle until the next completed operation.

Test Plan:
- Bench cell model: U = En & (X^Y^K_in), K_out = En & maj(X,Y,K_in). WIDTH=8 unless stated.
- a=0x35, b=0x4A, k0=0, start for 1 cycle -> busy high for 8 cycles; done at cycle 9; result=0x7F, k_final=0.
- a=0xFF, b=0x01, k0=0 -> result=0x00, k_final=1. Then a=0x00, b=0x00, k0=1 -> result=0x01, k_final=0.
- Start 0x12+0x34; during RUN pulse start with a=0xFF, b=0xFF -> ignored; result=0x46; exactly one done pulse.
- Start 0xAA+0x55 after a completed 0x7F result; abort at RUN cycle 4 -> no done; result stays 0x7F; busy=0 next cycle; a new start then completes normally.
- Assert rst at RUN cycle 3 -> all outputs 0 immediately; after release, IDLE ignores no-start cycles; cell_en=0 throughout IDLE/DONE.
- Exhaustive sweep with WIDTH=4: all 16x16x2 operand/k0 combinations -> {k_final,result} == a+b+k0 for every case.
